// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared constants for the data-memory arbiter (read-return FSM
//           encoding and default loader starvation bound).
// Revision: 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef logic [1:0] rd_state_t;

    localparam rd_state_t RD_NONE = 2'd0;
    localparam rd_state_t RD_CPU  = 2'd1;
    localparam rd_state_t RD_LDR  = 2'd2;

    localparam int MAX_WAIT_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Two-requester arbiter for the single-port data memory; processor
//           priority with bounded loader starvation and tagged read return.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    rd_state_t  rd_state;
    logic       loader_turn;

    assign loader_turn = (wait_cnt >= WAIT_LIMIT);

    // Grants are masked during reset so every output reads 0 while it is held.
    always_comb begin
        cpu_gnt = 1'b0;
        ldr_gnt = 1'b0;
        if (!reset) begin
            if (cpu_req && !(ldr_req && loader_turn)) begin
                cpu_gnt = 1'b1;
            end else if (ldr_req) begin
                ldr_gnt = 1'b1;
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt & ~reset;

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        mem_rden = 1'b0;
        if (cpu_gnt) begin
            mem_addr = cpu_addr;
            mem_data = cpu_wdata;
            mem_wren = cpu_we;
            mem_rden = ~cpu_we;
        end else if (ldr_gnt) begin
            mem_addr = ldr_addr;
            mem_data = ldr_wdata;
            mem_wren = ldr_we;
            mem_rden = ~ldr_we;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (!ldr_req || ldr_gnt) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt < WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // rd_state remembers who owns the data mem_q will present next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_state <= RD_NONE;
        end else if (cpu_gnt && !cpu_we) begin
            rd_state <= RD_CPU;
        end else if (ldr_gnt && !ldr_we) begin
            rd_state <= RD_LDR;
        end else begin
            rd_state <= RD_NONE;
        end
    end

    assign cpu_rvalid = (rd_state == RD_CPU);
    assign ldr_rvalid = (rd_state == RD_LDR);
    assign cpu_rdata  = cpu_rvalid ? mem_q : '0;
    assign ldr_rdata  = ldr_rvalid ? mem_q : '0;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single-port 8-bit data memory. It lets the multicycle processor and a program loader/debug port share the memory. It sits between the processor datapath (address mux, MemRead/MemWrite) and the `memory` instance. It grants at most one access per clock, with processor priority and bounded loader starvation, and it returns read data with a valid strobe to whichever requester issued the read.

## Interface
- `ADDR_W`, default 8: memory address width.
- `DATA_W`, default 8: memory data width.
- `MAX_WAIT`, default 4: number of consecutive denied loader cycles after which the loader wins the next contended cycle (range 1–15).

Ports (clock and reset first):
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cpu_req`  in  1  processor access request.
- `cpu_we`  in  1  processor access is a write.
- `cpu_addr`  in  ADDR_W  processor address.
- `cpu_wdata`  in  DATA_W  processor write data.
- `cpu_gnt`  out  1  processor access performed this cycle.
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`; the control FSM holds its state while high.
- `cpu_rvalid`  out  1  `cpu_rdata` is valid (one-cycle pulse).
- `cpu_rdata`  out  DATA_W  read data.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`  in  1/1/ADDR_W/DATA_W  loader request; same meaning as the processor signals.
- `ldr_gnt`, `ldr_rvalid`  out  1  loader grant and read-valid.
- `ldr_rdata`  out  DATA_W  read data.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_data`  out  DATA_W  memory write data.
- `mem_wren`  out  1  memory write enable.
- `mem_rden`  out  1  memory read enable.
- `mem_q`  in  DATA_W  memory read data, valid one cycle after `mem_rden`.

## Operation
- Grant decision is combinational from the current requests and the registered `wait_cnt`. At most one grant is high per cycle.
- Arbitration, per cycle:
  - Neither requester active: no grant.
  - Only one active: that requester is granted.
  - Both active and `wait_cnt < MAX_WAIT`: the processor is granted.
  - Both active and `wait_cnt == MAX_WAIT`: the loader is granted.
- `wait_cnt` (4 bits):
  - Increments when `ldr_req & ~ldr_gnt`.
  - Saturates at `MAX_WAIT`.
  - Clears to 0 when `ldr_gnt` is high or `ldr_req` is low.
- Memory port drive:
  - The granted requester's addr/wdata drive `mem_addr`/`mem_data`.
  - `mem_wren = gnt & we` and `mem_rden = gnt & ~we`.
  - With no grant, `mem_addr`/`mem_data` are 0 and both enables are 0.
- Read-return FSM (`rd_state`), transitions on the rising edge:
  - States: `RD_NONE`, `RD_CPU`, `RD_LDR`.
  - Next state is `RD_CPU` if a processor read is granted, `RD_LDR` if a loader read is granted, else `RD_NONE`.
  - `cpu_rvalid = (rd_state == RD_CPU)` and `ldr_rvalid = (rd_state == RD_LDR)`.
- Read data:
  - `cpu_rdata`/`ldr_rdata` equal `mem_q` while the matching rvalid is high, and 0 otherwise.
  - The requester must not depend on rdata outside rvalid.
- Writes produce no rvalid. A write granted in the cycle after a read does not disturb the returning read data.
- Back-to-back reads alternating between owners are legal. Each rvalid goes to the owner of the read issued in the previous cycle.
- Requesters hold req/we/addr/wdata stable until they see their grant. A request dropped before grant is abandoned with no side effects.

## Timing
- Grant latency: 0 cycles when uncontended. Write is committed on the granting edge.
- Read latency: rvalid and rdata arrive exactly 1 cycle after the grant cycle.
- Worst-case loader wait under continuous processor requests: `MAX_WAIT` denied cycles, then a grant on cycle `MAX_WAIT+1`.
- Values on reset:
  - All outputs are 0 in reset (`rd_state = RD_NONE`, `wait_cnt = 0`).
  - An outstanding read is discarded: no rvalid after reset deasserts.
- First grant is possible in the first clock edge after reset deasserts.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the `rd_state` encoding (`RD_NONE = 2'd0`, `RD_CPU = 2'd1`, `RD_LDR = 2'd2`);
  - the `MAX_WAIT` default.
- One flat module with no sub-modules. The grant logic, port mux and read-return FSM are small enough to live together.

## Test plan
- Processor-only read: `cpu_req=1, cpu_we=0, cpu_addr=0x10`, memory holds `0x5A` → `cpu_gnt=1` and `mem_rden=1` that cycle; next cycle `cpu_rvalid=1`, `cpu_rdata=0x5A`, `ldr_rvalid=0`.
- Loader write then processor read: `ldr` writes `0x3C` to `0x20`, then `cpu` reads `0x20` → `mem_wren` pulses once; the read returns `0x3C` one cycle after its grant.
- Starvation bound, `MAX_WAIT=4`: `cpu_req` held high every cycle, `ldr_req` high from cycle 0 → `ldr_gnt` on cycle 4; `cpu_stall=1` only on cycle 4; `wait_cnt` back to 0 on cycle 5.
- Alternating reads: `cpu` reads `0x01` in cycle n, `ldr` reads `0x02` in cycle n+1 → `cpu_rvalid` in n+1 with data at `0x01`, `ldr_rvalid` in n+2 with data at `0x02`; never both rvalids high.
- Reset mid-read: processor read granted, `reset` asserted before the next edge → no `cpu_rvalid` after reset releases; all outputs 0 during reset.
- Abandoned request: `ldr_req` high for 2 denied cycles, then dropped → `wait_cnt` returns to 0; no `ldr_gnt` and no memory access for the loader.
